iterative_divider: RTL and testbench
====================================

# iterative_divider

Multi-cycle, parametrised RV32M/RV64M divide/remainder unit for the EX stage of the 5-stage pipeline. It executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, producing one quotient bit per cycle. A start/busy/done handshake lets the hazard unit stall the pipeline. Divide-by-zero and signed overflow use RISC-V semantics and finish early. A synchronous flush aborts an in-flight operation on a branch mispredict or trap.

## Interface
- XLEN, 32, operand and result width; legal values are 32 and 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when the unit is in IDLE or DONE.
- flush  in  1  synchronous abort; has priority over start.
- div_opcode  in  2  selects the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- operand1  in  XLEN  dividend; sampled only on the accept edge.
- operand2  in  XLEN  divisor; sampled only on the accept edge.
- busy  out  1  high in the CALC and FIX states.
- done  out  1  one-cycle pulse; result_divide is valid in the same cycle.
- result_divide  out  XLEN  final result; held until the next accepted start or until reset.

## Operation
- States and transitions:
  - IDLE -> CALC on an accepted start, or IDLE/DONE -> DONE for special cases.
  - CALC -> FIX after XLEN iterations.
  - FIX -> DONE.
  - DONE -> IDLE, or -> CALC/DONE on a back-to-back start.
- Accept: on the accept edge, latch the opcode, sign flags, absolute values of the operands (signed ops only) and the raw dividend. Set the counter to XLEN.
- Absolute values are computed in XLEN-bit unsigned arithmetic, so the magnitude of 0x80000000 is 0x80000000.
- CALC iteration:
  - Form the trial value {rem[XLEN-1:0], quo[XLEN-1]} minus the divisor, using an XLEN+1-bit subtract.
  - If the trial value is non-negative, rem takes the trial value and a 1 is shifted into quo. Otherwise rem is shifted with the dividend bit and a 0 is shifted into quo.
  - Decrement the counter. Leave CALC when the counter reaches 0.
- FIX, signed ops only:
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend is negative.
  - The selected value is registered into result_divide.
- Special cases are decided on the accept edge, skip CALC/FIX and go straight to DONE:
  - divisor == 0: DIV/DIVU return all ones; REM/REMU return operand1.
  - DIV with 0x80..0 / all ones: returns 0x80..0.
  - REM with 0x80..0 / all ones: returns 0.
- Ignored inputs:
  - start while busy is ignored; no queueing.
  - Operand changes after accept are ignored.
- flush:
  - The next state is IDLE from any state.
  - done is not asserted and result_divide keeps its previous value.
  - start in the same cycle as flush is dropped.
- Unknown opcodes cannot occur, because all 2-bit encodings are defined.

## Timing
- Reset values: the state is IDLE, busy = 0, done = 0, result_divide = 0 and the counter is 0.
- Reset is asserted asynchronously and released synchronously by the upstream reset synchroniser.
- Reset mid-operation discards all work, and no done follows.
- Normal latency, with start sampled at edge T:
  - busy is high for cycles T+1 .. T+XLEN+1.
  - done and the result are valid in cycle T+XLEN+2; that is 34 cycles for XLEN=32.
- Special-case latency: done is high in cycle T+1, and busy is never asserted.
- Back-to-back: start sampled on the edge that ends the DONE cycle is accepted, giving a throughput of one op per XLEN+2 cycles.
- done is exactly one cycle wide. done and busy are never high together.
- flush sampled at edge F: busy is low from cycle F+1.

## Test plan
- Reset: hold rst_n low with start high -> busy=0, done=0, result_divide=0.
- DIVU 100 / 7, XLEN=32 -> done 34 cycles after start, result 14. Then REMU with the same operands -> result 2.
- Signed ops with -7 and 2:
  - DIV -7 / 2 -> 0xFFFFFFFD.
  - REM -7 / 2 -> 0xFFFFFFFF.
  - REM 7 / -2 -> 1.
- Special cases:
  - DIV x / 0 -> 0xFFFFFFFF, one cycle after start.
  - REMU 0x1234 / 0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, one cycle after start.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Flush at CALC cycle 10, with a new start issued 2 cycles later -> no done for the flushed op, the previous result is held, and the new op completes with the correct value.
- Ignore and back-to-back:
  - Pulse start while busy -> it is ignored and only one done follows.
  - Assert start in a DONE cycle -> the second op is accepted and its done arrives exactly 34 cycles later.
  - Rerun with XLEN=64 and random operands checked against a reference model -> the latency is 66 cycles.

Source files
------------

// File: rtl/iterative_divider.sv
// Radix-2 restoring divide/remainder unit for RV32M/RV64M (DIV, DIVU, REM, REMU).
// One quotient bit per cycle, start/busy/done handshake, early exit on x/0 and signed overflow.
module iterative_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result_divide
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("iterative_divider: XLEN must be 32 or 64");
    end

    localparam int               CNT_W    = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state, state_nxt;

    // Latched operation context and iteration datapath.
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  divisor;
    logic             is_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    // Opcode decode: bit 0 set means unsigned, bit 1 set means remainder.
    logic            is_signed;
    logic            is_rem;
    logic            op1_neg;
    logic            op2_neg;
    logic [XLEN-1:0] op1_abs;
    logic [XLEN-1:0] op2_abs;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic            accept;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        is_signed = ~div_opcode[0];
        is_rem    = div_opcode[1];
        op1_neg   = is_signed & operand1[XLEN-1];
        op2_neg   = is_signed & operand2[XLEN-1];
        // Magnitudes stay XLEN-bit unsigned, so the most negative value maps onto itself.
        op1_abs   = op1_neg ? -operand1 : operand1;
        op2_abs   = op2_neg ? -operand2 : operand2;
        div_zero  = (operand2 == '0);
        overflow  = is_signed && (operand1 == MIN_NEG) && (operand2 == '1);
        special   = div_zero | overflow;
        accept    = start && !flush && ((state == IDLE) || (state == DONE));
    end

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = is_rem ? operand1 : '1;
        end else if (overflow) begin
            special_result = is_rem ? '0 : MIN_NEG;
        end
    end

    // Restoring step: the top bit of the (XLEN+1)-bit difference is the borrow.
    always_comb begin
        trial = {rem, quo[XLEN-1]} - {1'b0, divisor};
    end

    always_comb begin
        if (is_rem_q) begin
            fix_result = neg_rem_q ? -rem : rem;
        end else begin
            fix_result = neg_quo_q ? -quo : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (accept) begin
                    state_nxt = special ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // NOTE: datapath registers are reset too, so a mid-operation reset leaves no stale work behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            divisor       <= '0;
            is_rem_q      <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            result_divide <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            is_rem_q  <= is_rem;
            neg_quo_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            divisor   <= op2_abs;
            quo       <= op1_abs;
            rem       <= '0;
            if (special) begin
                cnt           <= '0;
                result_divide <= special_result;
            end else begin
                cnt <= CNT_INIT;
            end
        end else if (state == CALC) begin
            if (!trial[XLEN]) begin
                rem <= trial[XLEN-1:0];
            end else begin
                rem <= {rem[XLEN-2:0], quo[XLEN-1]};
            end
            quo <= {quo[XLEN-2:0], ~trial[XLEN]};
            cnt <= cnt - CNT_ONE;
        end else if (state == FIX) begin
            result_divide <= fix_result;
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed vectors, multi-cycle corner
// sequences and randomized ops at XLEN=32 and XLEN=64 against an arithmetic model.
module tb_iterative_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        start32, start64;
    logic [1:0]  op;
    logic [63:0] a, b;
    logic        busy32, done32, busy64, done64;
    logic [31:0] res32;
    logic [63:0] res64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iterative_divider #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .flush(flush),
        .div_opcode(op), .operand1(a[31:0]), .operand2(b[31:0]),
        .busy(busy32), .done(done32), .result_divide(res32)
    );

    iterative_divider #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .flush(flush),
        .div_opcode(op), .operand1(a), .operand2(b),
        .busy(busy64), .done(done64), .result_divide(res64)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e, input int l);
        vec_t v;
        v.name = name; v.op = o; v.a = x; v.b = y; v.exp = e; v.lat = l;
        vecs.push_back(v);
    endtask

    // RISC-V M-extension semantics written directly with language arithmetic.
    function automatic logic [31:0] ref32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx = x;
        int sy = y;
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        case (o)
            OP_DIV:  return (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy);
            OP_DIVU: return x / y;
            OP_REM:  return (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h0 : 32'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        longint sx = x;
        longint sy = y;
        logic [63:0] mn = 64'h8000_0000_0000_0000;
        if (y == 0) return o[1] ? x : '1;
        case (o)
            OP_DIV:  return (x == mn && y == '1) ? x : 64'(sx / sy);
            OP_DIVU: return x / y;
            OP_REM:  return (x == mn && y == '1) ? 64'h0 : 64'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    function automatic int exp_lat(input bit w, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mn  = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        logic [63:0] all = w ? '1 : 64'h0000_0000_FFFF_FFFF;
        if (y == 0 || (!o[0] && x == mn && y == all)) return 1;
        return w ? 66 : 34;
    endfunction

    // Starts an op in the current cycle (caller sits on a negedge) and waits for done.
    task automatic run(input bit w, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output int lat, output int busy_cnt, output bit overlap);
        op = o; a = x; b = y;
        if (w) start64 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; start64 = 1'b0;
        lat = 1; busy_cnt = 0; overlap = 1'b0;
        while (!(w ? done64 : done32) && lat < 200) begin
            if (w ? busy64 : busy32) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        overlap = w ? busy64 : busy32;
        r = w ? res64 : {32'h0, res32};
    endtask

    task automatic do_check(input string name, input bit w, input logic [1:0] o,
                            input logic [63:0] x, input logic [63:0] y,
                            input logic [63:0] e, input int l);
        logic [63:0] r;
        int lat, bc;
        bit ov;
        run(w, o, x, y, r, lat, bc, ov);
        check({name, "_result"}, r, e);
        check({name, "_latency"}, 64'(lat), 64'(l));
        check({name, "_busy_cycles"}, 64'(bc), 64'((l == 1) ? 0 : l - 1));
        check({name, "_busy_with_done"}, 64'(ov), 64'(0));
        @(negedge clk);
        check({name, "_done_width"}, 64'(w ? done64 : done32), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, x, y;
        logic [1:0]  o;
        int lat, bc, dones, first_lat;
        bit ov;

        // Reset held with start high.
        rst_n = 1'b0; flush = 1'b0; start32 = 1'b1; start64 = 1'b1;
        op = OP_DIVU; a = 64'd100; b = 64'd7;
        repeat (3) @(negedge clk);
        check("reset_busy32", 64'(busy32), 64'(0));
        check("reset_done32", 64'(done32), 64'(0));
        check("reset_result32", 64'(res32), 64'(0));
        check("reset_busy64", 64'(busy64), 64'(0));
        check("reset_result64", res64, 64'(0));
        start32 = 1'b0; start64 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        add("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         34);
        add("remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          34);
        add("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        add("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        add("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34);
        add("div_m100_m7",  OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34);
        add("rem_m100_m7",  OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34);
        add("div_x_0",      OP_DIV,  32'd85,         32'd0,          32'hFFFF_FFFF,  1);
        add("divu_x_0",     OP_DIVU, 32'd85,         32'd0,          32'hFFFF_FFFF,  1);
        add("remu_1234_0",  OP_REMU, 32'h1234,       32'd0,          32'h1234,       1);
        add("rem_m7_0",     OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1);
        add("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        add("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        add("divu_no_ovf",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
        add("div_min_1",    OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  34);
        add("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34);
        add("remu_5_9",     OP_REMU, 32'd5,          32'd9,          32'd5,          34);
        foreach (vecs[i]) begin
            do_check(vecs[i].name, 1'b0, vecs[i].op, {32'h0, vecs[i].a}, {32'h0, vecs[i].b},
                     {32'h0, vecs[i].exp}, vecs[i].lat);
        end

        // Flush in CALC cycle 10, previous result held, new start two cycles later.
        do_check("pre_flush", 1'b0, OP_DIVU, 64'd100, 64'd7, 64'd14, 34);
        op = OP_DIVU; a = 64'd1000; b = 64'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy32), 64'(0));
        check("flush_done", 64'(done32), 64'(0));
        check("flush_result_held", 64'(res32), 64'd14);
        @(negedge clk);
        check("flush_idle_done", 64'(done32), 64'(0));
        do_check("after_flush", 1'b0, OP_REMU, 64'd1000, 64'd3, 64'd1, 34);

        // Start together with flush is dropped.
        op = OP_DIVU; a = 64'd50; b = 64'd5; start32 = 1'b1; flush = 1'b1;
        @(negedge clk);
        start32 = 1'b0; flush = 1'b0;
        check("start_flush_busy", 64'(busy32), 64'(0));
        check("start_flush_done", 64'(done32), 64'(0));

        // Start pulsed while busy (with new operands) is ignored.
        op = OP_DIVU; a = 64'd100; b = 64'd7; start32 = 1'b1;
        dones = 0; first_lat = 0; r = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) start32 = 1'b0;
            if (c == 5) begin op = OP_REM; a = 64'd1000; b = 64'd3; start32 = 1'b1; end
            if (c == 6) start32 = 1'b0;
            if (done32) begin
                dones++;
                if (first_lat == 0) begin first_lat = c; r = {32'h0, res32}; end
            end
        end
        check("ignore_done_count", 64'(dones), 64'd1);
        check("ignore_latency", 64'(first_lat), 64'd34);
        check("ignore_result", r, 64'd14);

        // Back-to-back: start in the DONE cycle, including special-case chaining.
        run(1'b0, OP_DIVU, 64'd100, 64'd7, r, lat, bc, ov);
        check("b2b_first_result", r, 64'd14);
        run(1'b0, OP_DIV, 64'h0000_0000_FFFF_FFF9, 64'd2, r, lat, bc, ov);
        check("b2b_second_result", r, 64'h0000_0000_FFFF_FFFD);
        check("b2b_second_latency", 64'(lat), 64'd34);
        run(1'b0, OP_DIV, 64'd9, 64'd0, r, lat, bc, ov);
        check("b2b_special_result", r, 64'h0000_0000_FFFF_FFFF);
        check("b2b_special_latency", 64'(lat), 64'd1);
        run(1'b0, OP_REMU, 64'd100, 64'd7, r, lat, bc, ov);
        check("b2b_after_special_result", r, 64'd2);
        check("b2b_after_special_latency", 64'(lat), 64'd34);
        @(negedge clk);

        // Reset mid-operation: work discarded, no done afterwards.
        op = OP_DIVU; a = 64'd100; b = 64'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy32), 64'(0));
        check("midreset_result", 64'(res32), 64'(0));
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32) dones++;
        end
        check("midreset_no_done", 64'(dones), 64'(0));

        // Randomized ops against the arithmetic model, both widths.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 24; i++) begin
                o = 2'($urandom_range(0, 3));
                x = {$urandom, $urandom};
                y = {$urandom, $urandom};
                case ($urandom_range(0, 7))
                    0: y = '0;
                    1: y = 64'($urandom_range(1, 15));
                    2: begin x = 64'h8000_0000_0000_0000; y = '1; end
                    3: y = -64'($urandom_range(1, 15));
                    default: ;
                endcase
                if (w == 0) begin
                    x = {32'h0, x[63:32] == 32'h8000_0000 ? 32'h8000_0000 : x[31:0]};
                    y = {32'h0, y[31:0]};
                end
                do_check($sformatf("rand%0d_%0d", w ? 64 : 32, i), w[0], o, x, y,
                         w ? ref64(o, x, y) : {32'h0, ref32(o, x[31:0], y[31:0])},
                         exp_lat(w[0], o, x, y));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
